// File: rtl/dpram_fifo_ctrl.sv
// FIFO controller driving the write (port 0) and read (port 1) sides of a dual-port RAM.
// Optional sticky overflow/underflow flags are enabled by defining FIFO_ERR_FLAGS_EN.
module dpram_fifo_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              full,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_valid,
  output logic              empty,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic              underflow,
  output logic              wr_en,
  output logic              port_enable_0,
  output logic [ADDR_W-1:0] address_in_0,
  output logic [DATA_W-1:0] din,
  output logic              port_enable_1,
  output logic [ADDR_W-1:0] address_in_1,
  input  logic [DATA_W-1:0] dout1
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W-1:0] wptr;
  logic [ADDR_W-1:0] rptr;
  logic              push_ok;
  logic              pop_ok;

  assign full    = (count == DEPTH);
  assign empty   = (count == '0);
  assign push_ok = push & ~full;
  assign pop_ok  = pop & ~empty;

  // RAM enables are gated by rst so no write or read escapes during reset
  assign wr_en         = push_ok & ~rst;
  assign port_enable_0 = push_ok & ~rst;
  assign port_enable_1 = pop_ok & ~rst;
  assign address_in_0  = wptr;
  assign address_in_1  = rptr;
  assign din           = push_data;
  assign pop_data      = dout1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      pop_valid <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + ADDR_W'(1);
      if (pop_ok)  rptr <= rptr + ADDR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + (ADDR_W+1)'(1);
        2'b01:   count <= count - (ADDR_W+1)'(1);
        default: count <= count;
      endcase
      pop_valid <= pop_ok;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push & full)  overflow  <= 1'b1;
      if (pop & empty)  underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// Scoreboard bench for dpram_fifo_ctrl with a behavioural RAM and queue-based FIFO reference.
module tb_dpram_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 4;
  localparam int DEPTH  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              full;
  logic              pop;
  logic [DATA_W-1:0] pop_data;
  logic              pop_valid;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;
  logic              wr_en;
  logic              port_enable_0;
  logic [ADDR_W-1:0] address_in_0;
  logic [DATA_W-1:0] din;
  logic              port_enable_1;
  logic [ADDR_W-1:0] address_in_1;
  logic [DATA_W-1:0] dout1;

  dpram_fifo_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .push(push), .push_data(push_data), .full(full),
    .pop(pop), .pop_data(pop_data), .pop_valid(pop_valid), .empty(empty),
    .count(count), .overflow(overflow), .underflow(underflow), .wr_en(wr_en),
    .port_enable_0(port_enable_0), .address_in_0(address_in_0), .din(din),
    .port_enable_1(port_enable_1), .address_in_1(address_in_1), .dout1(dout1)
  );

  always #5 clk = ~clk;

  // Behavioural dual-port RAM with registered read
  logic [DATA_W-1:0] mem [DEPTH];
  always @(posedge clk) begin
    if (wr_en) mem[address_in_0] <= din;
    if (port_enable_1) dout1 <= mem[address_in_1];
  end

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: contents queue, lifetime push/pop totals, sticky flags
  logic [DATA_W-1:0] m_q[$];
  logic [DATA_W-1:0] exp_q[$];
  int unsigned       n_push_tot;
  int unsigned       n_pop_tot;
  bit                m_ovf;
  bit                m_unf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    exp_q.delete();
    n_push_tot = 0;
    n_pop_tot  = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  // One clock cycle of stimulus; combinational and registered outputs checked before the edge
  task automatic cyc(input bit p, input logic [DATA_W-1:0] d, input bit q);
    bit pok, qok;
    @(negedge clk);
    push = p; push_data = d; pop = q;
    #1;
    pok = p && (m_q.size() < DEPTH);
    qok = q && (m_q.size() > 0);
    chk("count", 32'(count), 32'(m_q.size()));
    chk("full",  32'(full),  32'(m_q.size() == DEPTH));
    chk("empty", 32'(empty), 32'(m_q.size() == 0));
    chk("wr_en", 32'(wr_en), 32'(pok));
    chk("port_enable_0", 32'(port_enable_0), 32'(pok));
    chk("port_enable_1", 32'(port_enable_1), 32'(qok));
    if (pok) begin
      chk("address_in_0", 32'(address_in_0), n_push_tot % DEPTH);
      chk("din", 32'(din), 32'(d));
    end
    if (qok) chk("address_in_1", 32'(address_in_1), n_pop_tot % DEPTH);
    chk("overflow",  32'(overflow),  32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
`ifdef FIFO_ERR_FLAGS_EN
    if (p && m_q.size() == DEPTH) m_ovf = 1'b1;
    if (q && m_q.size() == 0) m_unf = 1'b1;
`endif
    if (qok) begin
      exp_q.push_back(m_q.pop_front());
      n_pop_tot++;
    end
    if (pok) begin
      m_q.push_back(d);
      n_push_tot++;
    end
  endtask

  // Monitor: every cycle pop_valid must match a pending expectation, and data must match it
  always @(negedge clk) begin
    if (!rst) begin
      chk("pop_valid", 32'(pop_valid), 32'(exp_q.size() > 0));
      if (pop_valid && exp_q.size() > 0) chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
    end
  end

  task automatic async_reset_check();
    @(negedge clk);
    push = 1'b1; push_data = 8'h55; pop = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_pop_valid", 32'(pop_valid), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_port_enable_0", 32'(port_enable_0), 32'd0);
    chk("rst_port_enable_1", 32'(port_enable_1), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_underflow", 32'(underflow), 32'd0);
    model_clear();
    @(negedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    rst = 1'b0;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; push = 1'b0; pop = 1'b0; push_data = '0;
    model_clear();
    #3;
    chk("init_count", 32'(count), 32'd0);
    chk("init_empty", 32'(empty), 32'd1);
    chk("init_full", 32'(full), 32'd0);
    chk("init_pop_valid", 32'(pop_valid), 32'd0);
    #9 rst = 1'b0;

    for (int i = 1; i <= 16; i++) cyc(1'b1, 8'(i), 1'b0);
    cyc(1'b1, 8'd17, 1'b0);                           // rejected at full
    cyc(1'b1, 8'd18, 1'b1);                           // full: only pop accepted
    cyc(1'b1, 8'd19, 1'b0);                           // refill to 16
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b1);                           // 17th pop rejected
    cyc(1'b1, 8'h77, 1'b1);                           // empty: only push accepted
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);

    async_reset_check();
    for (int i = 0; i < 10; i++) cyc(1'b1, 8'(i + 32), 1'b0);
    for (int i = 0; i < 10; i++) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'hA0 + i), 1'b0);
    for (int i = 0; i < 11; i++) cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b1, 8'hC5, 1'b1);                           // count 5: both ports active
    cyc(1'b1, 8'hC6, 1'b1);
    for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b1);

    for (int phase = 0; phase < 4; phase++) begin
      int unsigned pp = (phase % 2 == 0) ? 75 : 25;
      for (int i = 0; i < 100; i++)
        cyc($urandom_range(99) < pp, 8'($urandom), $urandom_range(99) >= pp);
    end

    while (m_q.size() > 0) cyc(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'($urandom), 1'b0);
    async_reset_check();
    cyc(1'b1, 8'h3C, 1'b0);                           // first write after reset goes to address 0
    cyc(1'b0, 8'h00, 1'b1);
    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dpram_fifo_ctrl.md
# dpram_fifo_ctrl

Synchronous FIFO controller that sits directly upstream of the 16x8 dual-port RAM (`dpram`) and drives both of its ports. It converts a producer push interface and a consumer pop interface into RAM write-port (port 0) and read-port (port 1) commands, and maintains wrap-around pointers, occupancy count and full/empty status. Storage lives entirely in `dpram`; this block holds only control state.

## Interface
Parameters:
- `DATA_W`, default 8: data width; must match `dpram` data width.
- `ADDR_W`, default 4: RAM address width; FIFO depth is 2^ADDR_W = 16.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `push`  in  1  producer requests a write.
- `push_data`  in  DATA_W  data to write.
- `full`  out  1  FIFO holds 2^ADDR_W entries.
- `pop`  in  1  consumer requests a read.
- `pop_data`  out  DATA_W  read data; valid only while `pop_valid` = 1.
- `pop_valid`  out  1  `pop_data` carries the word for the pop accepted on the previous cycle.
- `empty`  out  1  FIFO holds 0 entries.
- `count`  out  ADDR_W+1  current occupancy, 0..16.
- `overflow`  out  1  sticky: a push was rejected (see Configuration).
- `underflow`  out  1  sticky: a pop was rejected (see Configuration).
- `wr_en`  out  1  to `dpram.wr_en`.
- `port_enable_0`  out  1  to `dpram.port_enable_0`.
- `address_in_0`  out  ADDR_W  to `dpram.address_in_0` (write pointer).
- `din`  out  DATA_W  to `dpram.din`.
- `port_enable_1`  out  1  to `dpram.port_enable_1`.
- `address_in_1`  out  ADDR_W  to `dpram.address_in_1` (read pointer).
- `dout1`  in  DATA_W  from `dpram.dout1`.

## Operation
- Accepted push: `push_ok` = `push` & ~`full`.
- Accepted pop: `pop_ok` = `pop` & ~`empty`.
- Push is rejected when `full`, even if a pop is accepted in the same cycle. Pop is rejected when `empty`, even if a push is accepted in the same cycle.
- RAM write-side signals are combinational:
  - `wr_en` = `port_enable_0` = `push_ok`.
  - `address_in_0` = `wptr`.
  - `din` = `push_data`.
- RAM read-side signals are combinational:
  - `port_enable_1` = `pop_ok`.
  - `address_in_1` = `rptr`.
- While `rst` = 1, `wr_en`, `port_enable_0` and `port_enable_1` are forced to 0.
- Pointers are ADDR_W bits and wrap naturally from 15 to 0.
  - `wptr` increments on `push_ok`.
  - `rptr` increments on `pop_ok`.
- `count` update per cycle:
  - +1 on `push_ok` only.
  - −1 on `pop_ok` only.
  - Unchanged when both or neither occur.
- `full` = (`count` == 16); `empty` = (`count` == 0). Both are derived from the registered `count`.
- `pop_data` = `dout1` (pass-through). `pop_valid` is a register loaded with `pop_ok`.
- No read and write ever target the same address in one cycle: pop requires non-empty, and push requires non-full, so `wptr` ≠ `rptr` whenever both are active.
- Reset values:
  - `wptr` = `rptr` = 0, `count` = 0.
  - `empty` = 1, `full` = 0.
  - `pop_valid` = 0, `overflow` = `underflow` = 0.
- Reset asserted mid-operation discards all entries immediately. RAM contents are not cleared. A pop accepted in the cycle reset asserts produces no `pop_valid`.

## Timing
- Write: a push accepted in cycle N is stored in `dpram` at the end of cycle N. `count`, `empty` and `full` reflect it in cycle N+1.
- Read: a pop accepted in cycle N drives `address_in_1` in cycle N. `dpram` registers `dout1` at the end of cycle N. `pop_valid` = 1 and `pop_data` is valid in cycle N+1.
- Back-to-back pops give one word per cycle.
- A word pushed in cycle N can be popped in cycle N+1 at the earliest.
- Worst-case throughput: one push and one pop per cycle.

## Configuration
- `FIFO_ERR_FLAGS_EN` defined:
  - `overflow` sets on `push` & `full`.
  - `underflow` sets on `pop` & `empty`.
  - Both are sticky until `rst`.
- Not defined: `overflow` and `underflow` are tied to 0. No error registers are instantiated, and all other behaviour is identical.

## Test plan
- Reset, then push 1..16 in consecutive cycles → addresses 0..15 written; `count` = 16; `full` = 1; `empty` = 0.
- With the FIFO full, push 17 → no `wr_en`, `count` stays 16; `overflow` = 1 with `FIFO_ERR_FLAGS_EN`, 0 without.
- Pop 16 consecutive cycles → `pop_data` = 1..16, each one cycle after its pop; `empty` = 1 after the last. A 17th pop gives no `pop_valid` and sets `underflow` (macro defined).
- Wrap-around: push 10 and pop 10, then push 0xA0..0xAF → writes to addresses 10..15, 0..9; popping returns 0xA0..0xAF in order.
- Simultaneous push and pop:
  - At `count` = 5 → `count` stays 5 and both RAM ports are enabled.
  - At `count` = 0 → only the push is accepted; `count` = 1 and no `pop_valid`.
  - At `count` = 16 → only the pop is accepted; `count` = 15.
- Assert `rst` asynchronously mid-stream at `count` = 7 → outputs take reset values immediately (`empty` = 1, `count` = 0, `pop_valid` = 0, error flags = 0). The first push after release writes address 0.
